// File: rtl/div_32by16_seq_pkg.sv
// div_32by16_seq_pkg: shared state encoding and width constants for the sequential divider.
`default_nettype none

package div_32by16_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Same default operand width as the shift-add multiplier.
  localparam int DIV_W = 16;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_W);

endpackage

`default_nettype wire

// File: rtl/div_32by16_seq.sv
// div_32by16_seq: 2N-by-N unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Optional remainder output via DIV_REM_EN.  Rev 1.0
`default_nettype none

module div_32by16_seq
  import div_32by16_seq_pkg::*;
#(
  parameter int N = DIV_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dvd,
  input  logic [N-1:0]   dvs,
  output logic [N-1:0]   quo,
`ifdef DIV_REM_EN
  output logic [N-1:0]   rem,
`endif
  output logic           busy,
  output logic           done,
  output logic           dz,
  output logic           ovf
);

  localparam int CW = cnt_width(N);

  div_state_e     state, state_n;
  logic [N-1:0]   pr;
  logic [N-1:0]   sr;
  logic [N-1:0]   dvs_r;
  logic [CW-1:0]  cnt;

  logic [N-1:0]   dvd_hi;
  logic [N-1:0]   dvd_lo;
  logic           is_dz;
  logic           is_ovf;
  logic [N:0]     t;
  logic [N:0]     diff;
  logic           q_bit;
  logic [N-1:0]   pr_nxt;

  assign dvd_hi = dvd[2*N-1:N];
  assign dvd_lo = dvd[N-1:0];
  assign is_dz  = (dvs == '0);
  assign is_ovf = !is_dz && (dvd_hi >= dvs);

  // t is N+1 bits wide; since pr < dvs_r the result always fits back in N bits.
  assign t      = {pr, sr[N-1]};
  assign diff   = t - {1'b0, dvs_r};
  assign q_bit  = (t >= {1'b0, dvs_r});
  assign pr_nxt = q_bit ? diff[N-1:0] : t[N-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_n = (is_dz || is_ovf) ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (cnt == '0) state_n = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr    <= '0;
      sr    <= '0;
      dvs_r <= '0;
      cnt   <= '0;
      quo   <= '0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
`ifdef DIV_REM_EN
      rem   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            dvs_r <= dvs;
            pr    <= dvd_hi;
            sr    <= dvd_lo;
            cnt   <= CW'(N - 1);
            quo   <= '0;
            dz    <= is_dz;
            ovf   <= is_ovf;
`ifdef DIV_REM_EN
            rem   <= '0;
`endif
          end
        end
        ST_CALC: begin
          pr  <= pr_nxt;
          sr  <= {sr[N-2:0], 1'b0};
          quo <= {quo[N-2:0], q_bit};
          cnt <= cnt - 1'b1;
`ifdef DIV_REM_EN
          if (cnt == '0) rem <= pr_nxt;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_32by16_seq.sv
// tb_div_32by16_seq: directed self-checking bench for div_32by16_seq (works with or without DIV_REM_EN).
`default_nettype none

module tb_div_32by16_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dvd;
  logic [15:0] dvs;
  logic [15:0] quo;
`ifdef DIV_REM_EN
  logic [15:0] rem;
`endif
  logic        busy;
  logic        done;
  logic        dz;
  logic        ovf;

  int n_cmp = 0;
  int n_bad = 0;

  div_32by16_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .dvd   (dvd),
    .dvs   (dvs),
    .quo   (quo),
`ifdef DIV_REM_EN
    .rem   (rem),
`endif
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation; optionally pulse a second start at cycle pulse_at.
  // Cycles are counted from the edge after which start is driven.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [15:0] b,
                        input int exp_cyc, input logic [15:0] exp_q, input logic [15:0] exp_r,
                        input logic exp_dz, input logic exp_ovf, input int pulse_at);
    int n_done = 0;
    int done_cyc = -1;
    logic [15:0] q_s = '0;
    logic [15:0] r_s = '0;
    logic dz_s = 1'b0;
    logic ovf_s = 1'b0;
    start = 1'b1; dvd = a; dvs = b;
    tick();
    start = 1'b0; dvd = '0; dvs = '0;
    chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    for (int c = 1; c <= 30; c++) begin
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = c;
          q_s = quo; dz_s = dz; ovf_s = ovf;
`ifdef DIV_REM_EN
          r_s = rem;
`endif
        end
      end
      if (c == pulse_at) begin
        start = 1'b1; dvd = 32'h0000_0005; dvs = 16'h0000;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk({tag, "_ndone"}, n_done, 1);
    chk({tag, "_latency"}, done_cyc, exp_cyc);
    chk({tag, "_quo"}, {16'd0, q_s}, {16'd0, exp_q});
`ifdef DIV_REM_EN
    chk({tag, "_rem"}, {16'd0, r_s}, {16'd0, exp_r});
`else
    r_s = exp_r;
`endif
    chk({tag, "_dz"}, {31'd0, dz_s}, {31'd0, exp_dz});
    chk({tag, "_ovf"}, {31'd0, ovf_s}, {31'd0, exp_ovf});
    chk({tag, "_quo_held"}, {16'd0, quo}, {16'd0, exp_q});
    chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int c;
    int first;
    int second;
    rst_n = 1'b0; start = 1'b0; dvd = '0; dvs = '0;
    #12;
    chk("rst_quo", {16'd0, quo}, 32'd0);
`ifdef DIV_REM_EN
    chk("rst_rem", {16'd0, rem}, 32'd0);
`endif
    chk("rst_flags", {28'd0, busy, done, dz, ovf}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("basic",  32'd100000,   16'd300,    17, 16'd333,    16'd100,    1'b0, 1'b0, 0);
    run_op("maxq",   32'hFFFE0001, 16'hFFFF,   17, 16'hFFFF,   16'h0000,   1'b0, 1'b0, 0);
    run_op("small",  32'd1000,     16'd7,      17, 16'd142,    16'd6,      1'b0, 1'b0, 0);
    run_op("lowdvd", 32'h0000FFFF, 16'h0100,   17, 16'h00FF,   16'h00FF,   1'b0, 1'b0, 0);
    run_op("edge",   32'h00FF0000, 16'h0100,   17, 16'hFF00,   16'h0000,   1'b0, 1'b0, 0);
    run_op("dz",     32'h12345678, 16'h0000,   1,  16'h0000,   16'h0000,   1'b1, 1'b0, 0);
    run_op("ovf",    32'h00010000, 16'h0001,   1,  16'h0000,   16'h0000,   1'b0, 1'b1, 0);
    run_op("ovfeq",  32'h00FF0000, 16'h00FF,   1,  16'h0000,   16'h0000,   1'b0, 1'b1, 0);
    run_op("ignore", 32'd100000,   16'd300,    17, 16'd333,    16'd100,    1'b0, 1'b0, 5);

    // Mid-operation asynchronous reset.
    start = 1'b1; dvd = 32'd100000; dvs = 16'd300;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_quo", {16'd0, quo}, 32'd0);
    chk("abort_flags", {28'd0, busy, done, dz, ovf}, 32'd0);
    c = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) c++;
    end
    chk("abort_nodone", c, 0);
    rst_n = 1'b1;
    tick();
    run_op("postrst", 32'd100000, 16'd300, 17, 16'd333, 16'd100, 1'b0, 1'b0, 0);

    // start held high relaunches right after DONE: one op per 18 cycles.
    start = 1'b1; dvd = 32'd1000; dvs = 16'd7;
    first = -1; second = -1;
    for (int i = 1; i <= 60 && second < 0; i++) begin
      tick();
      if (done) begin
        if (first < 0) first = i;
        else begin
          second = i;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_first", first, 17);
    chk("b2b_second", second, 35);
    chk("b2b_quo", {16'd0, quo}, 32'd142);
    for (int i = 0; i < 3; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no summary expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/div_32by16_seq.md
# div_32by16_seq

Sequential unsigned restoring divider that reverses the 16-bit shift-add multiplier. It takes a 32-bit dividend (typically a multiplier product) and a 16-bit divisor, and produces a 16-bit quotient and remainder at one bit per clock. It sits next to the multiplier in the arithmetic datapath and uses the same start/done handshake style, so a controller can sequence the two blocks interchangeably.

## Interface
- N, 16, quotient/divisor width; dividend is 2N bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- dvd  in  2N  dividend, captured with start
- dvs  in  N  divisor, captured with start
- quo  out  N  quotient, held until next accepted start
- rem  out  N  remainder (present only with DIV_REM_EN)
- busy  out  1  high in CALC and DONE
- done  out  1  single-cycle completion pulse
- dz  out  1  divide-by-zero flag, valid with done, held
- ovf  out  1  quotient-overflow flag (dvd[2N-1:N] >= dvs, dvs≠0), valid with done, held

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 latches dvd and dvs, and clears quo, rem, dz and ovf.
  - If dvs==0: set dz and go to DONE.
  - Else if dvd[2N-1:N] >= dvs: set ovf and go to DONE.
  - Else: load the partial remainder with dvd[2N-1:N], load the low shift register with dvd[N-1:0], set the bit counter to N-1, and go to CALC.
- CALC, each cycle:
  - t = {pr, msb of shift reg} (N+1 bits).
  - If t >= dvs: pr = t - dvs and the quotient bit is 1. Else pr = t[N-1:0] and the quotient bit is 0.
  - Shift the quotient bit into the LSB of quo.
  - When the counter reaches 0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Flag cases: quo=0 and rem=0 when dz or ovf is set.
- Invariant: pr < dvs, so pr always fits in N bits; t needs N+1 bits.
- start while busy=1 is ignored, with no queuing. start held high re-launches on the first IDLE cycle after DONE using the operands present then.
- Operand inputs are don't-care outside the accepting cycle.

## Timing
- Reset values: quo=0, rem=0, busy=0, done=0, dz=0, ovf=0, state=IDLE.
- Normal latency: start accepted at edge k means done is high after edge k+N+1 (17 cycles for N=16), and results are valid in that same cycle.
- dz/ovf latency: done is high after edge k+1.
- busy rises after edge k and falls with the edge that leaves DONE.
- Back-to-back throughput: one operation per N+2 cycles.
- Reset asserted mid-operation aborts immediately: all outputs take reset values and no done pulse is emitted.

## Configuration
- DIV_REM_EN defined: the rem port exists and is registered from pr in the cycle entering DONE.
- DIV_REM_EN undefined: the rem port is absent, and pr remains internal only. Quotient, flags and timing are identical in both builds.

## Structure
- Shared package holds:
  - the state enum (IDLE, CALC, DONE);
  - a default width constant of 16, shared with the multiplier;
  - the counter width, clog2(N).
- No sub-module is needed for N=16.
- A natural optional split is div_step, a combinational single-bit compare/subtract stage, if unrolling is added later.

## Test plan
- dvd=100000, dvs=300 -> after 17 cycles quo=333, rem=100, dz=0, ovf=0.
- dvd=0xFFFE0001, dvs=0xFFFF -> quo=0xFFFF, rem=0, done at cycle 17.
- dvs=0, any dvd -> done after 1 cycle, dz=1, quo=0.
- dvd=0x00010000, dvs=0x0001 -> done after 1 cycle, ovf=1, quo=0.
- Pulse start again at cycle 5 of an operation -> ignored: first result is unchanged and exactly one done pulse occurs.
- Assert rst_n low at cycle 8 of an operation -> all outputs 0 immediately, no done; a new start after release gives correct results.
